inst_fetch_queue: RTL and testbench

Instruction queue between the IF branch-select/compress stage and decode. Accepts up to 4 compressed, in-order instructions per cycle, each with its predicted take/destination, branch checkpoint and exception tag. Stores them in a circular buffer and presents the oldest two entries to decode each cycle. Supports whole-queue flush on redirect and backpressure toward IF.

---
 rtl/inst_fetch_queue_pkg.sv | 43 ++++
 rtl/inst_queue_ram.sv | 29 ++
 rtl/inst_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared entry layout, field offsets and helpers for the instruction fetch queue.
// Entry fields are packed MSB-first: inst, pc, pred_take, pred_dest, pred_info, has_exc, is_refill, exc_code.
`ifndef INST_FETCH_QUEUE_DEFINES
`define INST_FETCH_QUEUE_DEFINES
`ifndef ALL_CHECKPOINT_LEN
`define ALL_CHECKPOINT_LEN 8
`endif
`define IFQ_DEPTH         16
`define IFQ_EXCCODE_LSB   0
`define IFQ_REFILL_BIT    5
`define IFQ_EXC_BIT       6
`define IFQ_PREDINFO_LSB  7
`define IFQ_PREDDEST_LSB  (`IFQ_PREDINFO_LSB + `ALL_CHECKPOINT_LEN)
`define IFQ_PREDTAKE_BIT  (`IFQ_PREDDEST_LSB + 32)
`define IFQ_PC_LSB        (`IFQ_PREDTAKE_BIT + 1)
`define IFQ_INST_LSB      (`IFQ_PC_LSB + 32)
`define IFQ_ENTRY_LEN     (`IFQ_INST_LSB + 32)
`endif

package inst_fetch_queue_pkg;

    localparam int IFQ_CKPT_W   = `ALL_CHECKPOINT_LEN;
    localparam int IFQ_WR_SLOTS = 4;
    localparam int IFQ_RD_SLOTS = 2;

    typedef struct packed {
        logic [31:0]           inst;
        logic [31:0]           pc;
        logic                  pred_take;
        logic [31:0]           pred_dest;
        logic [IFQ_CKPT_W-1:0] pred_info;
        logic                  has_exc;
        logic                  is_refill;
        logic [4:0]            exc_code;
    } ifq_entry_t;

    localparam int IFQ_ENTRY_W = `IFQ_ENTRY_LEN;

    function automatic logic [31:0] slot_pc(input logic [31:0] base, input int k);
        return base + 32'(4 * k);
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: DEPTH x W, four write ports at consecutive wrapping addresses, two async reads.
// Write latency 1 cycle; reads are combinational; no flow control of its own.
module inst_queue_ram #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [3:0]          i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [3:0][W-1:0]   i_wdat,
    input  logic [AW-1:0]       i_raddr,
    output logic [1:0][W-1:0]   o_rdat
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_waddr + AW'(k)] <= i_wdat[k];
            end
        end
    end

    assign o_rdat[0] = r_mem[i_raddr];
    assign o_rdat[1] = r_mem[i_raddr + AW'(1)];

endmodule

// File: rtl/inst_fetch_queue.sv
// IF-to-decode instruction queue: 4-wide in-order write, oldest two entries presented to decode.
// Latency 1 cycle (0 on empty queue with INST_QUEUE_BYPASS_EN); IFQ_ready_o drops below 4 free slots.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH  = `IFQ_DEPTH,
    parameter  int CKPT_W = IFQ_CKPT_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IF_valid_i,
    input  logic [2:0]            IF_instNum_i,
    input  logic [127:0]          IF_inst_p_i,
    input  logic [31:0]           IF_instBasePC_i,
    input  logic [3:0]            IF_predTake_p_i,
    input  logic [127:0]          IF_predDest_p_i,
    input  logic [4*CKPT_W-1:0]   IF_predInfo_p_i,
    input  logic                  IF_hasException_i,
    input  logic                  IF_isRefill_i,
    input  logic [4:0]            IF_ExcCode_i,
    output logic                  IFQ_ready_o,
    input  logic                  flush_i,
    input  logic [1:0]            ID_acceptNum_i,
    output logic [1:0]            IFQ_valid_o,
    output logic [63:0]           IFQ_inst_p_o,
    output logic [63:0]           IFQ_PC_p_o,
    output logic [63:0]           IFQ_predDest_p_o,
    output logic [1:0]            IFQ_predTake_o,
    output logic [2*CKPT_W-1:0]   IFQ_predInfo_p_o,
    output logic [1:0]            IFQ_hasException_o,
    output logic [1:0]            IFQ_isRefill_o,
    output logic [9:0]            IFQ_ExcCode_p_o,
    output logic [CW-1:0]         IFQ_count_o
);

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_wr_acc;
    logic             w_byp;
    logic [2:0]       w_wnum;
    logic [1:0]       w_vld;
    logic [1:0]       w_vcnt;
    logic [1:0]       w_rnum;
    logic [3:0]       w_we;
    ifq_entry_t [3:0] w_went;
    ifq_entry_t [1:0] w_rdat;
    ifq_entry_t [1:0] w_oslot;

    // Readiness looks only at registered occupancy so IF never depends on decode timing.
    assign IFQ_ready_o = (r_count <= CW'(DEPTH - IFQ_WR_SLOTS));
    assign w_wr_acc    = IF_valid_i && IFQ_ready_o && !flush_i;
    assign w_wnum      = !w_wr_acc ? 3'd0 : ((IF_instNum_i > 3'd4) ? 3'd4 : IF_instNum_i);

    always_comb begin
        w_we   = '0;
        w_went = '0;
        for (int k = 0; k < IFQ_WR_SLOTS; k++) begin
            w_we[k]             = (3'(k) < w_wnum);
            w_went[k].inst      = IF_inst_p_i[32*k +: 32];
            w_went[k].pc        = slot_pc(IF_instBasePC_i, k);
            w_went[k].pred_take = IF_predTake_p_i[k];
            w_went[k].pred_dest = IF_predDest_p_i[32*k +: 32];
            w_went[k].pred_info = IF_predInfo_p_i[CKPT_W*k +: CKPT_W];
            w_went[k].has_exc   = IF_hasException_i;
            w_went[k].is_refill = IF_isRefill_i;
            w_went[k].exc_code  = IF_ExcCode_i;
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .W     (IFQ_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_tail),
        .i_wdat  (w_went),
        .i_raddr (r_head),
        .o_rdat  (w_rdat)
    );

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: forward the incoming write straight to decode. The write still lands
    // at tail; head skipping past the consumed part keeps those entries out of the queue.
    assign w_byp = (r_count == '0) && (w_wnum != 3'd0);
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        if (w_byp) begin
            w_vld = (w_wnum >= 3'd2) ? 2'b11 : 2'b01;
        end else begin
            w_vld = {(r_count > CW'(1)), (r_count > CW'(0))};
        end
        w_vcnt = {1'b0, w_vld[0]} + {1'b0, w_vld[1]};
        w_rnum = (ID_acceptNum_i < w_vcnt) ? ID_acceptNum_i : w_vcnt;
    end

    always_comb begin
        w_oslot            = '0;
        IFQ_inst_p_o       = '0;
        IFQ_PC_p_o         = '0;
        IFQ_predDest_p_o   = '0;
        IFQ_predTake_o     = '0;
        IFQ_predInfo_p_o   = '0;
        IFQ_hasException_o = '0;
        IFQ_isRefill_o     = '0;
        IFQ_ExcCode_p_o    = '0;
        for (int j = 0; j < IFQ_RD_SLOTS; j++) begin
            if (w_vld[j]) begin
                w_oslot[j] = w_byp ? w_went[j] : w_rdat[j];
            end
            IFQ_inst_p_o[32*j +: 32]            = w_oslot[j].inst;
            IFQ_PC_p_o[32*j +: 32]              = w_oslot[j].pc;
            IFQ_predDest_p_o[32*j +: 32]        = w_oslot[j].pred_dest;
            IFQ_predTake_o[j]                   = w_oslot[j].pred_take;
            IFQ_predInfo_p_o[CKPT_W*j +: CKPT_W] = w_oslot[j].pred_info;
            IFQ_hasException_o[j]               = w_oslot[j].has_exc;
            IFQ_isRefill_o[j]                   = w_oslot[j].is_refill;
            IFQ_ExcCode_p_o[5*j +: 5]           = w_oslot[j].exc_code;
        end
    end

    assign IFQ_valid_o = w_vld;
    assign IFQ_count_o = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_rnum);
            r_tail  <= r_tail + AW'(w_wnum);
            r_count <= r_count + CW'(w_wnum) - CW'(w_rnum);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: stimulus pushes expected entries, a monitor pops/compares.
module tb_inst_fetch_queue;

    localparam int DEPTH  = 16;
    localparam int CKPT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 IF_valid_i = 1'b0;
    logic [2:0]           IF_instNum_i = '0;
    logic [127:0]         IF_inst_p_i = '0;
    logic [31:0]          IF_instBasePC_i = '0;
    logic [3:0]           IF_predTake_p_i = '0;
    logic [127:0]         IF_predDest_p_i = '0;
    logic [4*CKPT_W-1:0]  IF_predInfo_p_i = '0;
    logic                 IF_hasException_i = 1'b0;
    logic                 IF_isRefill_i = 1'b0;
    logic [4:0]           IF_ExcCode_i = '0;
    logic                 flush_i = 1'b0;
    logic [1:0]           ID_acceptNum_i = '0;
    logic                 IFQ_ready_o;
    logic [1:0]           IFQ_valid_o;
    logic [63:0]          IFQ_inst_p_o;
    logic [63:0]          IFQ_PC_p_o;
    logic [63:0]          IFQ_predDest_p_o;
    logic [1:0]           IFQ_predTake_o;
    logic [2*CKPT_W-1:0]  IFQ_predInfo_p_o;
    logic [1:0]           IFQ_hasException_o;
    logic [1:0]           IFQ_isRefill_o;
    logic [9:0]           IFQ_ExcCode_p_o;
    logic [4:0]           IFQ_count_o;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .CKPT_W(CKPT_W)) dut (
        .clk(clk), .rst(rst),
        .IF_valid_i(IF_valid_i), .IF_instNum_i(IF_instNum_i), .IF_inst_p_i(IF_inst_p_i),
        .IF_instBasePC_i(IF_instBasePC_i), .IF_predTake_p_i(IF_predTake_p_i),
        .IF_predDest_p_i(IF_predDest_p_i), .IF_predInfo_p_i(IF_predInfo_p_i),
        .IF_hasException_i(IF_hasException_i), .IF_isRefill_i(IF_isRefill_i),
        .IF_ExcCode_i(IF_ExcCode_i), .IFQ_ready_o(IFQ_ready_o), .flush_i(flush_i),
        .ID_acceptNum_i(ID_acceptNum_i), .IFQ_valid_o(IFQ_valid_o),
        .IFQ_inst_p_o(IFQ_inst_p_o), .IFQ_PC_p_o(IFQ_PC_p_o),
        .IFQ_predDest_p_o(IFQ_predDest_p_o), .IFQ_predTake_o(IFQ_predTake_o),
        .IFQ_predInfo_p_o(IFQ_predInfo_p_o), .IFQ_hasException_o(IFQ_hasException_o),
        .IFQ_isRefill_o(IFQ_isRefill_o), .IFQ_ExcCode_p_o(IFQ_ExcCode_p_o),
        .IFQ_count_o(IFQ_count_o)
    );

    typedef struct {
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [31:0]       dest;
        logic              take;
        logic [CKPT_W-1:0] info;
        logic              exc;
        logic              refill;
        logic [4:0]        code;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] seq = 32'h0000_0100;
    logic [31:0] next_pc = 32'hBFC0_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_idle();
        IF_valid_i = 1'b0; IF_instNum_i = '0; ID_acceptNum_i = '0; flush_i = 1'b0;
        IF_hasException_i = 1'b0; IF_isRefill_i = 1'b0; IF_ExcCode_i = '0;
    endtask

    // One clock of stimulus; the expected entries are queued once the write is accepted.
    task automatic cyc(input bit v, input int n, input bit exc, input bit refill,
                       input logic [4:0] code, input int acc, input bit fl);
        exp_t        e [4];
        bit          will_acc;
        int          wn;
        logic [31:0] t;
        logic [31:0] base;
        @(negedge clk);
        base = next_pc;
        for (int k = 0; k < 4; k++) begin
            t            = seq + 32'(k);
            e[k].inst    = 32'hA000_0000 + t;
            e[k].pc      = base + 32'(4 * k);
            e[k].dest    = {t[15:0], ~t[15:0]};
            e[k].take    = t[0];
            e[k].info    = t[7:0] ^ 8'h3C;
            e[k].exc     = exc;
            e[k].refill  = refill;
            e[k].code    = code;
            IF_inst_p_i[32*k +: 32]         = e[k].inst;
            IF_predDest_p_i[32*k +: 32]     = e[k].dest;
            IF_predTake_p_i[k]              = e[k].take;
            IF_predInfo_p_i[CKPT_W*k +: CKPT_W] = e[k].info;
        end
        IF_valid_i = v; IF_instNum_i = 3'(n); IF_instBasePC_i = base;
        IF_hasException_i = exc; IF_isRefill_i = refill; IF_ExcCode_i = code;
        ID_acceptNum_i = 2'(acc); flush_i = fl;
        wn = (n > 4) ? 4 : n;
        will_acc = v && !fl && (exp_q.size() <= DEPTH - 4) && (wn > 0);
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (will_acc) begin
            for (int k = 0; k < wn; k++) exp_q.push_back(e[k]);
            next_pc = base + 32'(4 * wn);
        end
        seq = seq + 32'h10;
    endtask

    // Monitor: compare presented slots against the oldest expected entries, pop what decode takes.
    initial begin
        int   exp_n;
        int   pop_n;
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !mon_en) continue;
            exp_n = (exp_q.size() > 2) ? 2 : exp_q.size();
            chk("count", 64'(IFQ_count_o), 64'(exp_q.size()));
            chk("ready", 64'(IFQ_ready_o), 64'(exp_q.size() <= DEPTH - 4));
            chk("valid", 64'(IFQ_valid_o), (exp_n == 2) ? 64'd3 : 64'(exp_n));
            for (int j = 0; j < 2; j++) begin
                if (j < exp_n) begin
                    x = exp_q[j];
                    chk($sformatf("slot%0d_inst_pc", j),
                        {IFQ_inst_p_o[32*j +: 32], IFQ_PC_p_o[32*j +: 32]}, {x.inst, x.pc});
                    chk($sformatf("slot%0d_meta", j),
                        64'({IFQ_predDest_p_o[32*j +: 32], IFQ_predTake_o[j],
                             IFQ_predInfo_p_o[CKPT_W*j +: CKPT_W], IFQ_hasException_o[j],
                             IFQ_isRefill_o[j], IFQ_ExcCode_p_o[5*j +: 5]}),
                        64'({x.dest, x.take, x.info, x.exc, x.refill, x.code}));
                end else begin
                    chk($sformatf("slot%0d_zero", j),
                        {IFQ_inst_p_o[32*j +: 32], IFQ_PC_p_o[32*j +: 32]}, 64'd0);
                end
            end
            if (!flush_i) begin
                pop_n = (int'(ID_acceptNum_i) < exp_n) ? int'(ID_acceptNum_i) : exp_n;
                repeat (pop_n) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", 64'(IFQ_count_o), 64'd0);
        chk("rst_valid", 64'(IFQ_valid_o), 64'd0);
        chk("rst_ready", 64'(IFQ_ready_o), 64'd1);
        chk("rst_data", IFQ_PC_p_o | IFQ_inst_p_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // First write of four at the boot vector, nothing consumed.
        cyc(1, 4, 0, 0, 5'd0, 0, 0);
        #1;
        chk("first_valid", 64'(IFQ_valid_o), 64'd3);
        chk("first_pc", IFQ_PC_p_o, 64'hBFC0_0004_BFC0_0000);

        // Fill until ready drops, then keep trying: writes must be ignored.
        repeat (5) cyc(1, 4, 0, 0, 5'd0, 0, 0);
        #1;
        chk("full_count", 64'(IFQ_count_o), 64'd16);
        // Full queue still drains.
        repeat (4) cyc(0, 0, 0, 0, 5'd0, 2, 0);
        repeat (8) cyc(0, 0, 0, 0, 5'd0, 1, 0);

        // Refill to 12 and stream 3 in / 2 out across the pointer wrap.
        repeat (3) cyc(1, 4, 0, 0, 5'd0, 0, 0);
        repeat (24) cyc(1, 3, 0, 0, 5'd0, 2, 0);

        // Drain down to one entry, then over-accept.
        for (int i = 0; i < 20 && exp_q.size() > 1; i++) cyc(0, 0, 0, 0, 5'd0, 1, 0);
        cyc(0, 0, 0, 0, 5'd0, 2, 0);
        #1;
        chk("overaccept_count", 64'(IFQ_count_o), 64'd0);
        cyc(0, 0, 0, 0, 5'd0, 2, 0);

        // Zero-length write and an oversize instNum (clamped to 4).
        cyc(1, 0, 0, 0, 5'd0, 0, 0);
        cyc(1, 7, 0, 0, 5'd0, 0, 0);
        cyc(1, 1, 0, 1, 5'd0, 1, 0);

        // Flush beats a same-cycle write and read.
        cyc(1, 4, 0, 0, 5'd0, 2, 1);
        #1;
        chk("flush_count", 64'(IFQ_count_o), 64'd0);
        chk("flush_ready", 64'(IFQ_ready_o), 64'd1);

        // Exception tag replicated across the write.
        cyc(1, 2, 1, 0, 5'h04, 0, 0);
        #1;
        chk("exc_flags", 64'(IFQ_hasException_o), 64'd3);
        chk("exc_code", 64'(IFQ_ExcCode_p_o), 64'h084);
        cyc(1, 3, 1, 1, 5'h1F, 2, 0);
        repeat (3) cyc(0, 0, 0, 0, 5'd0, 2, 0);

        // Asynchronous reset in the middle of a write.
        cyc(1, 4, 0, 0, 5'd0, 0, 0);
        cyc(1, 4, 0, 0, 5'd0, 1, 0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_count", 64'(IFQ_count_o), 64'd0);
        chk("arst_valid", 64'(IFQ_valid_o), 64'd0);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 2, 0, 0, 5'd0, 0, 0);
        cyc(0, 0, 0, 0, 5'd0, 2, 0);
        cyc(0, 0, 0, 0, 5'd0, 0, 0);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
